// File: rtl/ssp_pkg.sv
// ssp_pkg: shared SSP word/pointer types and default FIFO sizing.
package ssp_pkg;
    localparam int SSP_WORD_W       = 8;
    localparam int SSP_TXFIFO_DEPTH = 4;
    localparam int SSP_PTR_W        = $clog2(SSP_TXFIFO_DEPTH) + 1;
    typedef logic [SSP_WORD_W-1:0] ssp_word_t;
    typedef logic [SSP_PTR_W-1:0]  ssp_ptr_t;
endpackage

// File: rtl/ssp_tx_fifo_if.sv
// ssp_tx_fifo_if: host write bus and talker read port of the SSP transmit FIFO.
// Carries level/txhalf only when SSP_TXFIFO_LEVEL_EN is defined.
interface ssp_tx_fifo_if
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WORD_W,
    parameter int DEPTH = SSP_TXFIFO_DEPTH
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic             psel;
    logic             pwrite;
    logic [WIDTH-1:0] pwdata;
    logic             txfifo_rw;
    logic             ovf_clr;
    logic [WIDTH-1:0] txdata;
    logic             txhasword;
    logic             ssptxintr;
    logic             txovf;
`ifdef SSP_TXFIFO_LEVEL_EN
    logic [PW-1:0]    level;
    logic             txhalf;
`endif
    modport master (
        output psel, pwrite, pwdata, txfifo_rw, ovf_clr,
        input  txdata, txhasword, ssptxintr, txovf
`ifdef SSP_TXFIFO_LEVEL_EN
        , input level, txhalf
`endif
    );
    modport slave (
        input  psel, pwrite, pwdata, txfifo_rw, ovf_clr,
        output txdata, txhasword, ssptxintr, txovf
`ifdef SSP_TXFIFO_LEVEL_EN
        , output level, txhalf
`endif
    );
endinterface

// File: rtl/ssp_fifo_ptr.sv
// ssp_fifo_ptr: wrap-bit FIFO pointer; counts modulo 2^W on each enabled pclk edge.
module ssp_fifo_ptr
    import ssp_pkg::*;
#(
    parameter int W = SSP_PTR_W
) (
    input  logic         pclk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge pclk or negedge clear)
        if (!clear) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: first-word-fall-through SSP transmit FIFO with full flag and sticky overflow.
// Optional SSP_TXFIFO_LEVEL_EN adds occupancy level and half-empty outputs.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WORD_W,
    parameter int DEPTH = SSP_TXFIFO_DEPTH
) (
    input logic          pclk,
    input logic          clear,
    ssp_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             empty, full, push_req, pop_ok, push_ok, txovf_q;
    always_comb begin
        empty    = wptr == rptr;
        full     = wptr == {~rptr[AW], rptr[AW-1:0]};
        push_req = bus.psel & bus.pwrite;
        pop_ok   = ~bus.txfifo_rw & ~empty;
        push_ok  = push_req & (~full | pop_ok);
    end
    ssp_fifo_ptr #(.W(PW)) u_wptr (.pclk(pclk), .clear(clear), .inc(push_ok), .ptr(wptr));
    ssp_fifo_ptr #(.W(PW)) u_rptr (.pclk(pclk), .clear(clear), .inc(pop_ok),  .ptr(rptr));
    always_ff @(posedge pclk)
        if (push_ok) mem[wptr[AW-1:0]] <= bus.pwdata;
    // A fresh overflow outranks a same-cycle clear request.
    always_ff @(posedge pclk or negedge clear)
        if (!clear) txovf_q <= 1'b0;
        else if (push_req & full & ~pop_ok) txovf_q <= 1'b1;
        else if (bus.ovf_clr) txovf_q <= 1'b0;
    assign bus.txdata    = empty ? '0 : mem[rptr[AW-1:0]];
    assign bus.txhasword = ~empty;
    assign bus.ssptxintr = full;
    assign bus.txovf     = txovf_q;
`ifdef SSP_TXFIFO_LEVEL_EN
    logic [PW-1:0] lvl;
    assign lvl        = wptr - rptr;
    assign bus.level  = lvl;
    assign bus.txhalf = lvl <= PW'(DEPTH / 2);
`endif
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: directed and random stimulus against a queue model of the transmit FIFO.
module tb_ssp_tx_fifo;
    localparam int DEPTH = 4;
    logic pclk, clear;
    int errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    int m_occ = 0;
    bit m_ovf = 0;

    ssp_tx_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();
    ssp_tx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (.pclk(pclk), .clear(clear), .bus(bus.slave));

    initial begin
        pclk = 0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        chk("txhasword", 32'(bus.txhasword), 32'(m_occ != 0));
        chk("ssptxintr", 32'(bus.ssptxintr), 32'(m_occ == DEPTH));
        chk("txovf", 32'(bus.txovf), 32'(m_ovf));
        chk("txdata", 32'(bus.txdata), m_occ != 0 ? 32'(exp_q[0]) : 32'h0);
`ifdef SSP_TXFIFO_LEVEL_EN
        chk("level", 32'(bus.level), 32'(m_occ));
        chk("txhalf", 32'(bus.txhalf), 32'(m_occ <= DEPTH / 2));
`endif
        if (!bus.txfifo_rw && m_occ > 0) void'(exp_q.pop_front());
    end

    task automatic step(bit push, logic [7:0] d, bit pop, bit clr);
        bit pop_ok, push_ok, ovf_n;
        bus.psel      = push;
        bus.pwrite    = push;
        bus.pwdata    = d;
        bus.txfifo_rw = !pop;
        bus.ovf_clr   = clr;
        pop_ok  = pop && m_occ > 0;
        push_ok = push && (m_occ < DEPTH || pop_ok);
        ovf_n   = (push && m_occ == DEPTH && !pop_ok) ? 1'b1 : clr ? 1'b0 : m_ovf;
        @(posedge pclk);
        #1;
        if (push_ok) exp_q.push_back(d);
        m_occ = m_occ + int'(push_ok) - int'(pop_ok);
        m_ovf = ovf_n;
    endtask

    initial begin
        clear = 0;
        bus.psel = 0; bus.pwrite = 0; bus.pwdata = '0; bus.txfifo_rw = 1; bus.ovf_clr = 0;
        repeat (3) @(posedge pclk);
        #1 clear = 1;
        step(1, 8'hA5, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        foreach (exp_q[i]) ;
        for (int i = 1; i <= 4; i++) step(1, 8'(i * 8'h11), 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 0, 0, 0);
        step(1, 8'h66, 1, 0);
        step(1, 8'h5A, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(1, 8'h77, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(i), 0, 0);
        for (int i = 4; i < 10; i++) step(1, 8'(i), 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        #2;
        clear = 0;
        exp_q.delete();
        m_occ = 0;
        m_ovf = 0;
        #1;
        chk("rst_txdata", 32'(bus.txdata), 32'h0);
        chk("rst_txhasword", 32'(bus.txhasword), 32'h0);
        chk("rst_ssptxintr", 32'(bus.ssptxintr), 32'h0);
        chk("rst_txovf", 32'(bus.txovf), 32'h0);
        @(posedge pclk);
        #2 clear = 1;
        step(1, 8'h99, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit FIFO for the SSP block. It sits between the host write bus and the talker.
- Host side: accepts 8-bit words on the APB-style write strobe.
- Talker side: presents the oldest word first-word-fall-through on txdata, raises txhasword while non-empty, and pops one word per talker read request (txfifo_rw low).
- Flags full via ssptxintr and records overflow.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; must be a power of two, at least 2.

Ports:
- pclk  in  1  SSP system clock; all state updates on rising edge.
- clear  in  1  asynchronous active-low reset.
- psel  in  1  bus select for this FIFO.
- pwrite  in  1  bus write qualifier; a push request is psel & pwrite.
- pwdata  in  WIDTH  word to push.
- txfifo_rw  in  1  talker request: 0 = pop (read) request, 1 = idle.
- txdata  out  WIDTH  oldest stored word (head); 0 when empty.
- txhasword  out  1  high while FIFO holds at least 1 word.
- ssptxintr  out  1  high while FIFO is full (DEPTH words).
- txovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of txovf.

Behaviour:
- Storage is a DEPTH x WIDTH register array. Read and write pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when the pointers are fully equal. Full when the low bits are equal and the MSBs differ.
- Reset (clear low, asynchronous, any time including mid-transfer):
  - Both pointers go to 0.
  - txovf = 0, txhasword = 0, ssptxintr = 0, txdata = 0.
  - Array contents are not reset.
- Push (rising pclk, psel & pwrite):
  - If not full: mem[wptr] <= pwdata and wptr increments.
  - If full with no pop in the same cycle: word dropped, wptr unchanged, txovf set to 1 from the next cycle.
- Pop (rising pclk, txfifo_rw == 0):
  - If not empty: rptr increments and txdata shows the next entry the following cycle.
  - If empty: ignored, no pointer change, no error flag.
- Simultaneous push and pop:
  - Not full and not empty: both proceed; occupancy unchanged.
  - Full: pop frees a slot and the push is accepted; no overflow.
  - Empty: push accepted, pop ignored. The new word appears on txdata one cycle later; it does not fall through in the same cycle.
- txdata = mem[rptr low bits] when non-empty, else 0. It is driven from registers plus a mux, with no added latency after the push edge.
- Latency:
  - A word pushed at edge N is visible on txdata, with txhasword = 1, after edge N.
  - ssptxintr asserts after the edge that makes the FIFO full and deasserts after the first pop edge.
- Pointer wrap: wraps modulo 2*DEPTH; the low bits wrap modulo DEPTH without a discontinuity.
- txovf:
  - Cleared by ovf_clr at the clock edge.
  - If ovf_clr and a new overflow occur in the same cycle, the set wins.
- All outputs derive from registered state only; there is no combinational path from inputs to outputs.

Optional Feature:
- SSP_TXFIFO_LEVEL_EN defined: adds output level [log2(DEPTH):0] = wptr - rptr, range 0..DEPTH, updated on the same edges as the pointers. Also adds output txhalf = (level <= DEPTH/2), used for a half-empty refill interrupt.
- Not defined: neither port exists and no level subtractor is built. All other behaviour is identical.

Decomposition:
- Shared package ssp_pkg holds:
  - SSP_WORD_W = 8 and SSP_TXFIFO_DEPTH = 4.
  - SSP_PTR_W = $clog2(SSP_TXFIFO_DEPTH) + 1.
  - typedef ssp_word_t (logic [SSP_WORD_W-1:0]).
  - typedef ssp_ptr_t (logic [SSP_PTR_W-1:0]).
- The package is reused by the talker and the future RX FIFO.
- One sub-module, ssp_fifo_ptr: a wrap-bit pointer counter with async active-low clear and an increment enable. It is instantiated twice and is reusable for the RX FIFO.

Test Plan:
- Reset, then push 0xA5 -> next cycle txhasword = 1, txdata = 0xA5, ssptxintr = 0.
- Push 0x11, 0x22, 0x33, 0x44 -> ssptxintr = 1. Push 0x55 -> txovf = 1, the word is dropped. Four pops return 0x11, 0x22, 0x33, 0x44, then txhasword = 0 and txdata = 0.
- Full FIFO, push 0x66 with simultaneous pop -> no overflow, occupancy stays 4, and 0x66 is read out last.
- Empty FIFO, simultaneous push 0x77 and pop -> pop ignored, txdata = 0x77 next cycle. A pop with the FIFO empty changes nothing.
- Ten push/pop pairs of 0x00..0x09, crossing pointer wrap twice -> data order is preserved. With SSP_TXFIFO_LEVEL_EN, level tracks 0..4 and txhalf = 1 at level <= 2.
- Assert clear mid-stream with 3 words stored -> all outputs go to 0 immediately (asynchronously, before the next pclk edge). After release, push 0x99 -> txdata = 0x99 with no stale words.
